// File: rtl/sine_sched_pkg.sv
// Shared types and helpers for the sine_sched round-robin phase sequencer.
package sine_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Channel-ID width; a lone channel still needs one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_acc_bank.sv
// Per-channel phase accumulators, increments and (with SINE_SCHED_OFFSET_EN) phase offsets.
// One read/advance port for the issuing slot, one config write port.
module phase_acc_bank
    import sine_sched_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int ACC_WIDTH     = 16,
    parameter int ADDRESS_WIDTH = 8,
    parameter int CH_W          = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_adv,
    input  logic [CH_W-1:0]          i_slot,
    output logic [ADDRESS_WIDTH-1:0] o_addr,
    input  logic                     i_we,
    input  logic [CH_W-1:0]          i_ch,
    input  logic [ACC_WIDTH-1:0]     i_incr,
`ifdef SINE_SCHED_OFFSET_EN
    input  logic [ADDRESS_WIDTH-1:0] i_off,
`endif
    input  logic                     i_sync
);

    logic [ACC_WIDTH-1:0] r_acc  [NUM_CH];
    logic [ACC_WIDTH-1:0] r_incr [NUM_CH];

`ifdef SINE_SCHED_OFFSET_EN
    logic [ADDRESS_WIDTH-1:0] r_off [NUM_CH];
    assign o_addr = r_acc[i_slot][ACC_WIDTH-1 -: ADDRESS_WIDTH] + r_off[i_slot];
`else
    assign o_addr = r_acc[i_slot][ACC_WIDTH-1 -: ADDRESS_WIDTH];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i]  <= '0;
                r_incr[i] <= '0;
`ifdef SINE_SCHED_OFFSET_EN
                r_off[i]  <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Sync overrides the step; the step reads the pre-write increment.
                if (i_sync)
                    r_acc[i] <= '0;
                else if (i_adv && i_slot == CH_W'(i))
                    r_acc[i] <= r_acc[i] + r_incr[i];
                if (i_we && i_ch == CH_W'(i)) begin
                    r_incr[i] <= i_incr;
`ifdef SINE_SCHED_OFFSET_EN
                    r_off[i]  <= i_off;
`endif
                end
            end
        end
    end

endmodule

// File: rtl/sine_sched.sv
// Round-robin phase sequencer sharing one registered sine ROM across NUM_CH channels.
// Optional per-channel phase offset enabled by SINE_SCHED_OFFSET_EN.
module sine_sched
    import sine_sched_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_CH        = 4,
    parameter int ACC_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       cfg_we,
    input  logic [ch_w(NUM_CH)-1:0]    cfg_ch,
    input  logic [ACC_WIDTH-1:0]       cfg_incr,
    input  logic                       cfg_sync,
`ifdef SINE_SCHED_OFFSET_EN
    input  logic [ADDRESS_WIDTH-1:0]   cfg_off,
`endif
    output logic [ADDRESS_WIDTH-1:0]   rom_addr,
    input  logic [DATA_WIDTH-1:0]      rom_data,
    output logic                       ch_valid,
    output logic [ch_w(NUM_CH)-1:0]    ch_id,
    output logic [DATA_WIDTH-1:0]      ch_data,
    output logic                       frame_done
);

    localparam int CH_W = ch_w(NUM_CH);

    state_t                   r_state, w_next;
    logic [CH_W-1:0]          r_slot;
    logic [1:0]               r_vld_pipe;
    logic [CH_W-1:0]          r_id0, r_id1;
    logic [ADDRESS_WIDTH-1:0] r_rom_addr, w_addr;
    logic                     r_ch_valid, r_frame_done;
    logic [CH_W-1:0]          r_ch_id;
    logic [DATA_WIDTH-1:0]    r_ch_data;
    logic                     w_issue;

    // RUN with en low issues nothing, so a falling en never adds a sample.
    assign w_issue = (r_state == RUN) && en;

    phase_acc_bank #(
        .NUM_CH        (NUM_CH),
        .ACC_WIDTH     (ACC_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .CH_W          (CH_W)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .i_adv  (w_issue),
        .i_slot (r_slot),
        .o_addr (w_addr),
        .i_we   (cfg_we),
        .i_ch   (cfg_ch),
        .i_incr (cfg_incr),
`ifdef SINE_SCHED_OFFSET_EN
        .i_off  (cfg_off),
`endif
        .i_sync (cfg_sync)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (en) w_next = RUN;
            RUN:     if (!en) w_next = DRAIN;
            DRAIN:   if (en) w_next = RUN;
                     else if (r_vld_pipe == 2'b00) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_slot       <= '0;
            r_vld_pipe   <= '0;
            r_id0        <= '0;
            r_id1        <= '0;
            r_rom_addr   <= '0;
            r_ch_valid   <= 1'b0;
            r_ch_id      <= '0;
            r_ch_data    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_vld_pipe <= {r_vld_pipe[0], w_issue};
            r_id1      <= r_id0;
            if (w_issue) begin
                r_rom_addr <= w_addr;
                r_id0      <= r_slot;
                r_slot     <= (r_slot == CH_W'(NUM_CH - 1)) ? '0 : r_slot + 1'b1;
            end
            // rom_data here is the ROM's registered response to the address issued two edges ago.
            r_ch_valid   <= r_vld_pipe[1];
            r_frame_done <= r_vld_pipe[1] && (r_id1 == CH_W'(NUM_CH - 1));
            if (r_vld_pipe[1]) begin
                r_ch_id   <= r_id1;
                r_ch_data <= rom_data;
            end
        end
    end

    assign rom_addr   = r_rom_addr;
    assign ch_valid   = r_ch_valid;
    assign ch_id      = r_ch_id;
    assign ch_data    = r_ch_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sine_sched.sv
// Self-checking bench for sine_sched: directed scenarios plus random traffic,
// compared against a cycle-level behavioural model of issue order and phase arithmetic.
module tb_sine_sched;
    import sine_sched_pkg::*;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int N    = 4;
    localparam int ACCW = 16;
    localparam int CW   = ch_w(N);

    logic          clk = 1'b0;
    logic          rst, en, cfg_we, cfg_sync;
    logic [CW-1:0] cfg_ch;
    logic [ACCW-1:0] cfg_incr;
`ifdef SINE_SCHED_OFFSET_EN
    logic [AW-1:0] cfg_off;
`endif
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          ch_valid, frame_done;
    logic [CW-1:0] ch_id;
    logic [DW-1:0] ch_data;

    always #5 clk = ~clk;

    sine_sched #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(N), .ACC_WIDTH(ACCW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_incr   (cfg_incr),
        .cfg_sync   (cfg_sync),
`ifdef SINE_SCHED_OFFSET_EN
        .cfg_off    (cfg_off),
`endif
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ch_valid   (ch_valid),
        .ch_id      (ch_id),
        .ch_data    (ch_data),
        .frame_done (frame_done)
    );

    // Stand-in ROM: a bijective byte mapping so every address gives a distinct sample.
    function automatic logic [7:0] rom_f(input logic [7:0] a);
        logic [7:0] t;
        t = a * 8'd37 + 8'd11;
        return t;
    endfunction

    always @(posedge clk) rom_data <= rom_f(rom_addr);

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: a channel is issued at an edge exactly when en is high at that edge and
    // at the edge before (and no reset in between); its sample shows two edges later.
    int unsigned m_acc [N];
    int unsigned m_incr[N];
    int unsigned m_off [N];
    int          m_slot;
    bit          m_prev_en;
    int unsigned m_addr;
    int          cyc = 0;
    bit          s_v [4];
    int          s_id[4];
    int unsigned s_a [4];
    bit          e_v, e_fd;
    int          e_id;
    int unsigned e_data;

    task automatic step(input bit r, input bit e, input bit we, input int ch,
                        input int inc, input bit sy, input int of);
        int k;
        rst      = r;
        en       = e;
        cfg_we   = we;
        cfg_ch   = ch[CW-1:0];
        cfg_incr = inc[ACCW-1:0];
        cfg_sync = sy;
`ifdef SINE_SCHED_OFFSET_EN
        cfg_off  = of[AW-1:0];
`endif
        cyc++;
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                m_acc[i] = 0; m_incr[i] = 0; m_off[i] = 0;
            end
            for (int i = 0; i < 4; i++) s_v[i] = 0;
            m_slot = 0; m_prev_en = 0; m_addr = 0;
            e_v = 0; e_id = 0; e_data = 0; e_fd = 0;
        end else begin
            k = cyc % 4;
            e_v = s_v[k];
            if (e_v) begin
                e_id   = s_id[k];
                e_data = rom_f(s_a[k][7:0]);
            end
            e_fd   = e_v && (e_id == N - 1);
            s_v[k] = 0;
            if (e && m_prev_en) begin
                m_addr = ((m_acc[m_slot] >> (ACCW - AW)) + m_off[m_slot]) % (1 << AW);
                s_v [(cyc + 2) % 4] = 1;
                s_id[(cyc + 2) % 4] = m_slot;
                s_a [(cyc + 2) % 4] = m_addr;
                if (!sy) m_acc[m_slot] = (m_acc[m_slot] + m_incr[m_slot]) % (1 << ACCW);
                m_slot = (m_slot + 1) % N;
            end
            if (sy) for (int i = 0; i < N; i++) m_acc[i] = 0;
            if (we) begin
                m_incr[ch] = inc % (1 << ACCW);
`ifdef SINE_SCHED_OFFSET_EN
                m_off[ch]  = of % (1 << AW);
`endif
            end
            m_prev_en = e;
        end
        @(negedge clk);
        chk("rom_addr",   32'(rom_addr),   m_addr);
        chk("ch_valid",   32'(ch_valid),   32'(e_v));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        if (e_v || !r) begin
            chk("ch_id",   32'(ch_id),   32'(e_id));
            chk("ch_data", 32'(ch_data), e_data);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to_slot(input int s);
        // At most N steps reach any slot while running.
        for (int i = 0; i < N + 2 && m_slot != s; i++) step(1, 1, 0, 0, 0, 0, 0);
        chk("reach_slot", 32'(m_slot), 32'(s));
    endtask

    initial begin
        rst = 0; en = 0; cfg_we = 0; cfg_sync = 0; cfg_ch = '0; cfg_incr = '0;
`ifdef SINE_SCHED_OFFSET_EN
        cfg_off = '0;
`endif
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

        // All increments zero: ids cycle, data is rom[0], frame_done every 4th.
        run(14);

        // incr[1]=0x0100 then incr[0]=0x8000 wraps slot 0 between 0x00 and 0x80.
        step(1, 1, 1, 1, 'h0100, 0, 0);
        run(16);
        step(1, 1, 1, 0, 'h8000, 0, 0);
        run(16);

        // Drop en right after slot 2 issues; resume must continue with slot 3.
        run_to_slot(3);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0);
        run(8);

        // Rewrite incr[1] in the cycle slot 1 issues.
        run_to_slot(1);
        step(1, 1, 1, 1, 'h0200, 0, 0);
        run(12);

        // Sync mid-run, then sync together with a config write.
        step(1, 1, 0, 0, 0, 1, 0);
        run(6);
        step(1, 1, 1, 2, 'h0300, 1, 0);
        run(10);

`ifdef SINE_SCHED_OFFSET_EN
        // Offsets: 0x40 with zero increment, then 0xF0 against a moving accumulator.
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 2, 0, 0, 'h40);
        run(10);
        step(1, 1, 1, 2, 'h2000, 0, 'hF0);
        run(16);
`endif

        // Reset with samples in flight: nothing may appear afterwards.
        run(3);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, we, sy;
            int ch, inc, of;
            r   = ($urandom_range(0, 199) != 0);
            e   = ($urandom_range(0, 9) < 8);
            we  = ($urandom_range(0, 9) == 0);
            sy  = ($urandom_range(0, 39) == 0);
            ch  = $urandom_range(0, N - 1);
            inc = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 'hFFFF))
                                              : int'($urandom_range(0, 'h3FF));
            of  = $urandom_range(0, 255);
            step(r, e, we, ch, inc, sy, of);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sine_sched.md
# sine_sched

Round-robin phase sequencer that shares one registered-output sine ROM between NUM_CH independent tone channels. Each cycle it issues one channel's ROM address from that channel's phase accumulator, then advances the accumulator by the channel's frequency increment. It tags the returning ROM sample with its channel ID. It sits between the host configuration interface and the ROM instance, which receives `rom_addr` and returns `rom_data`, and it feeds the per-channel output/DAC logic.

## Interface
- ADDRESS_WIDTH, 8: ROM address width.
- DATA_WIDTH, 8: ROM sample width.
- NUM_CH, 4: number of channels; must be at least 2; need not be a power of two.
- ACC_WIDTH, 16: phase accumulator width; must be at least ADDRESS_WIDTH.
- clk  in  1  single clock; all logic on the posedge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  run enable.
- cfg_we  in  1  write strobe for the increment of channel `cfg_ch`.
- cfg_ch  in  CH_W  target channel; CH_W = max(1, $clog2(NUM_CH)).
- cfg_incr  in  ACC_WIDTH  frequency increment.
- cfg_sync  in  1  clears all accumulators to 0.
- cfg_off  in  ADDRESS_WIDTH  per-channel phase offset, written with `cfg_we`; present only with SINE_SCHED_OFFSET_EN.
- rom_addr  out  ADDRESS_WIDTH  ROM address (registered).
- rom_data  in  DATA_WIDTH  ROM output; valid one cycle after `rom_addr`.
- ch_valid  out  1  `ch_data` and `ch_id` valid.
- ch_id  out  CH_W  channel of `ch_data`.
- ch_data  out  DATA_WIDTH  sample.
- frame_done  out  1  one-cycle pulse with `ch_valid` for channel NUM_CH-1.

## Operation
- Reset (rst=0 at a posedge) clears the following to 0: `rom_addr`, `ch_valid`, `ch_id`, `ch_data`, `frame_done`, all accumulators, all increments, all offsets, the slot counter, and both pipeline valid bits. The FSM goes to IDLE.
- Reset mid-operation discards in-flight samples; no `ch_valid` follows the reset.
- FSM states:
  - IDLE: nothing issued. Goes to RUN when en=1.
  - RUN: issues slot `s` each cycle. Goes to DRAIN when en=0.
  - DRAIN: issues nothing; the two pipeline stages empty. Goes to IDLE once both valid bits are 0, or back to RUN if en=1.
- Issue of slot `s`:
  - `rom_addr <= acc[s][ACC_WIDTH-1 -: ADDRESS_WIDTH]`, plus `off[s]` with the macro; the sum is taken mod 2^ADDRESS_WIDTH.
  - `acc[s] <= acc[s] + incr[s]`, mod 2^ACC_WIDTH.
  - `s` increments and wraps from NUM_CH-1 to 0.
- Slot counter holds while not in RUN. Re-enabling resumes at the next un-issued slot.
- cfg_we on the slot being issued in the same cycle: the old increment is used for that step; the new value applies from the next visit.
- cfg_sync with an issue in the same cycle: sync wins, so all accumulators become 0 and the issuing slot is not advanced. The address already sampled for that cycle is still issued. In-flight samples are still delivered.
- cfg_sync and cfg_we in the same cycle: both take effect.

## Timing
- Issue at edge k: `rom_addr` valid after edge k; the ROM registers the data at edge k+1; `ch_valid`, `ch_id` and `ch_data` are registered at edge k+2.
- Fixed latency of 2 cycles; throughput of 1 sample per cycle in RUN.
- `ch_valid` is a per-cycle qualifier; there is no backpressure.
- After en falls, exactly the samples already issued (at most 2) still appear.
- `frame_done` is asserted together with `ch_valid` when ch_id = NUM_CH-1.

## Configuration
- SINE_SCHED_OFFSET_EN defined:
  - the `cfg_off` port and a per-channel offset register bank exist;
  - the offset is added to the issued address.
- SINE_SCHED_OFFSET_EN undefined:
  - no port and no registers;
  - address = accumulator MSBs.

## Structure
- Package `sine_sched_pkg` holds:
  - the FSM state enum (IDLE, RUN, DRAIN);
  - the `ch_w` function computing CH_W from NUM_CH.
- Sub-module `phase_acc_bank` holds the accumulators, increments and optional offsets, with one read/advance port for slot `s` and one config write port.
- The top holds the FSM, the slot counter and the 2-stage valid/ID pipeline.

## Test plan
Parameters for all scenarios: NUM_CH=4, ACC_WIDTH=16, ADDRESS_WIDTH=8.
- Reset, then en=1 with all increments 0 → `ch_valid` rises 2 cycles after the first issue; `ch_id` runs 0,1,2,3,0…; `ch_data` = rom[0]; `frame_done` every 4th valid.
- incr[1]=0x0100 → slot-1 addresses 0x00, 0x01, 0x02…; other slots stay 0x00.
- incr[0]=0x8000 → slot-0 addresses 0x00, 0x80, 0x00, 0x80 (wrap).
- en=0 right after slot 2 is issued → two more valid samples (ch_id 1, 2), then none; en=1 → next issue is slot 3.
- cfg_we to ch 1 (0x0100→0x0200) in the cycle slot 1 issues → next slot-1 addresses are 0x01, then 0x03.
- With SINE_SCHED_OFFSET_EN: off[2]=0x40, incr=0 → slot-2 `rom_addr`=0x40; off[2]=0xF0 with acc MSBs 0x20 → 0x10.
